// File: rtl/spi_pkg.sv
// spi_pkg: state encoding, SPI mode encodings and counter sizing shared by
// spi_master_param and spi_clk_gen.
`default_nettype none

package spi_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SETUP = 2'd1,
      XFER  = 2'd2,
      HOLD  = 2'd3
   } state_t;

   // SPI mode encodings as {cpol, cpha}
   localparam logic [1:0] MODE0 = 2'b00;
   localparam logic [1:0] MODE1 = 2'b01;
   localparam logic [1:0] MODE2 = 2'b10;
   localparam logic [1:0] MODE3 = 2'b11;

   function automatic int half_cnt_w(input int clk_div);
      return (clk_div > 1) ? $clog2(clk_div) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_gen.sv
// spi_clk_gen: SCLK half-period timer; emits half-period-end strobes and
// leading/trailing edge strobes plus the count of edges seen in XFER.
`default_nettype none

module spi_clk_gen
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int EDGE_W  = $clog2(2*DATA_W+1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              run,
   input  logic              xfer,
   output logic              half_end,
   output logic              lead,
   output logic              trail,
   output logic [EDGE_W-1:0] edge_cnt
);

   localparam int CNT_W = half_cnt_w(CLK_DIV);

   logic [CNT_W-1:0] cnt;

   assign half_end = run && (cnt == CNT_W'(CLK_DIV-1));
   // even-numbered half-periods end on a leading edge, odd ones on a trailing edge
   assign lead     = half_end && xfer && !edge_cnt[0];
   assign trail    = half_end && xfer &&  edge_cnt[0];

   always_ff @(posedge clk) begin
      if (rst || !run || half_end)
         cnt <= '0;
      else
         cnt <= cnt + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (rst || !xfer)
         edge_cnt <= '0;
      else if (half_end)
         edge_cnt <= edge_cnt + 1'b1;
   end

endmodule

`default_nettype wire

// File: rtl/spi_master_param.sv
// spi_master_param: parametrised SPI master with runtime CPOL/CPHA and NUM_SS selects.
// Optional macro SPI_BIT_ORDER_EN adds the lsb_first input for LSB-first transfers.
`default_nettype none

module spi_master_param
   import spi_pkg::*;
#(
   parameter int DATA_W  = 8,
   parameter int CLK_DIV = 2,
   parameter int NUM_SS  = 1,
   parameter int SEL_W   = (NUM_SS > 1) ? $clog2(NUM_SS) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data_in,
   input  logic              ready_send,
   input  logic              cpol,
   input  logic              cpha,
   input  logic [SEL_W-1:0]  ss_sel,
`ifdef SPI_BIT_ORDER_EN
   input  logic              lsb_first,
`endif
   input  logic              miso,
   output logic              mosi,
   output logic              sclk,
   output logic [NUM_SS-1:0] ss,
   output logic              busy,
   output logic              done,
   output logic [DATA_W-1:0] data_out
);

   localparam int EDGE_W = $clog2(2*DATA_W+1);

   state_t            state, state_nx;
   logic [DATA_W-1:0] tx_sr, tx_sr_nx, rx_sr, rx_sr_nx, data_out_nx;
   logic [DATA_W-1:0] tx_word, rx_word;
   logic [NUM_SS-1:0] ss_nx, ss_dec;
   logic              mosi_nx, sclk_nx, done_nx;
   logic              cpol_lat, cpol_lat_nx, cpha_lat, cpha_lat_nx, lsb_lat, lsb_lat_nx;
   logic              lsb_in, sample_on_lead, last_edge;
   logic              half_end, lead, trail;
   logic [EDGE_W-1:0] edge_cnt;

`ifdef SPI_BIT_ORDER_EN
   assign lsb_in = lsb_first;
`else
   assign lsb_in = 1'b0;
`endif

   assign busy           = (state != IDLE);
   assign sample_on_lead = ({cpol_lat, cpha_lat} == MODE0) || ({cpol_lat, cpha_lat} == MODE2);
   assign last_edge      = (edge_cnt == EDGE_W'(2*DATA_W-1));

   spi_clk_gen #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV),
      .EDGE_W  (EDGE_W)
   ) u_clk_gen (
      .clk      (clk),
      .rst      (rst),
      .run      (busy),
      .xfer     (state == XFER),
      .half_end (half_end),
      .lead     (lead),
      .trail    (trail),
      .edge_cnt (edge_cnt)
   );

   // LSB-first is handled by reversing words at the edges; the shifters stay MSB-first
   always_comb begin
      tx_word = data_in;
      rx_word = rx_sr;
      for (int i = 0; i < DATA_W; i++) begin
         if (lsb_in)  tx_word[i] = data_in[DATA_W-1-i];
         if (lsb_lat) rx_word[i] = rx_sr[DATA_W-1-i];
      end
      ss_dec = '0;
      for (int i = 0; i < NUM_SS; i++)
         if (ss_sel == SEL_W'(i)) ss_dec[i] = 1'b1;
   end

   always_comb begin
      state_nx    = state;
      tx_sr_nx    = tx_sr;
      rx_sr_nx    = rx_sr;
      data_out_nx = data_out;
      ss_nx       = ss;
      mosi_nx     = mosi;
      sclk_nx     = sclk;
      done_nx     = 1'b0;
      cpol_lat_nx = cpol_lat;
      cpha_lat_nx = cpha_lat;
      lsb_lat_nx  = lsb_lat;
      case (state)
         IDLE: begin
            sclk_nx = cpol;
            ss_nx   = '1;
            if (ready_send) begin
               state_nx    = SETUP;
               tx_sr_nx    = tx_word;
               mosi_nx     = tx_word[DATA_W-1];
               cpol_lat_nx = cpol;
               cpha_lat_nx = cpha;
               lsb_lat_nx  = lsb_in;
               ss_nx       = ~ss_dec;
            end
         end
         SETUP: begin
            if (half_end) state_nx = XFER;
         end
         XFER: begin
            if (half_end) sclk_nx = ~sclk;
            if (sample_on_lead) begin
               if (lead) rx_sr_nx = {rx_sr[DATA_W-2:0], miso};
               if (trail && !last_edge) begin
                  mosi_nx  = tx_sr[DATA_W-2];
                  tx_sr_nx = {tx_sr[DATA_W-2:0], 1'b0};
               end
            end else begin
               if (trail) rx_sr_nx = {rx_sr[DATA_W-2:0], miso};
               if (lead) begin
                  mosi_nx  = tx_sr[DATA_W-1];
                  tx_sr_nx = {tx_sr[DATA_W-2:0], 1'b0};
               end
            end
            if (half_end && last_edge) state_nx = HOLD;
         end
         HOLD: begin
            if (half_end) begin
               state_nx    = IDLE;
               ss_nx       = '1;
               done_nx     = 1'b1;
               data_out_nx = rx_word;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         tx_sr    <= '0;
         rx_sr    <= '0;
         data_out <= '0;
         ss       <= '1;
         mosi     <= 1'b0;
         sclk     <= 1'b0;
         done     <= 1'b0;
         cpol_lat <= 1'b0;
         cpha_lat <= 1'b0;
         lsb_lat  <= 1'b0;
      end else begin
         state    <= state_nx;
         tx_sr    <= tx_sr_nx;
         rx_sr    <= rx_sr_nx;
         data_out <= data_out_nx;
         ss       <= ss_nx;
         mosi     <= mosi_nx;
         sclk     <= sclk_nx;
         done     <= done_nx;
         cpol_lat <= cpol_lat_nx;
         cpha_lat <= cpha_lat_nx;
         lsb_lat  <= lsb_lat_nx;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_spi_master_param.sv
// tb_spi_master_param: directed tests of spi_master_param with a behavioural SPI slave.
`default_nettype none

module tb_spi_master_param;

   localparam int DATA_W  = 8;
   localparam int CLK_DIV = 2;
   localparam int NUM_SS  = 3;
   localparam int SEL_W   = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [DATA_W-1:0] data_in = '0;
   logic              ready_send = 1'b0;
   logic              cpol = 1'b0;
   logic              cpha = 1'b0;
   logic [SEL_W-1:0]  ss_sel = '0;
`ifdef SPI_BIT_ORDER_EN
   logic              lsb_first = 1'b0;
`endif
   logic              miso = 1'b0;
   logic              mosi, sclk, busy, done;
   logic [NUM_SS-1:0] ss;
   logic [DATA_W-1:0] data_out;

   spi_master_param #(
      .DATA_W  (DATA_W),
      .CLK_DIV (CLK_DIV),
      .NUM_SS  (NUM_SS),
      .SEL_W   (SEL_W)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .data_in    (data_in),
      .ready_send (ready_send),
      .cpol       (cpol),
      .cpha       (cpha),
      .ss_sel     (ss_sel),
`ifdef SPI_BIT_ORDER_EN
      .lsb_first  (lsb_first),
`endif
      .miso       (miso),
      .mosi       (mosi),
      .sclk       (sclk),
      .ss         (ss),
      .busy       (busy),
      .done       (done),
      .data_out   (data_out)
   );

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // slave / monitor state
   logic        cfg_cpol = 1'b0, cfg_cpha = 1'b0, cfg_lsb = 1'b0;
   logic [7:0]  cfg_miso = '0;
   logic [2:0]  exp_ss = 3'b111;
   logic        prev_sclk = 1'b0, prev_busy = 1'b0, prev_mosi = 1'b0;
   logic        edge_seen, lead_seen;
   int          busy_run = 0, idle_run = 0, gap_last = 0, done_cnt = 0;
   int          done_run = 0, done_max = 0, ss_bad = 0, mosi_tbad = 0, miso_idx = 0;
   logic [7:0]  mosi_cap = '0;
   logic [7:0]  data_q [32];
   logic [7:0]  mosi_q [32];
   int          busy_q [32];

   function automatic logic miso_bit(input int b);
      return cfg_lsb ? cfg_miso[b] : cfg_miso[7-b];
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         prev_busy = 1'b0;
         done_run  = 0;
      end else begin
         if (busy && !prev_busy) begin
            gap_last = idle_run;
            idle_run = 0;
            busy_run = 0;
            mosi_cap = '0;
            if (!cfg_cpha) begin
               miso     = miso_bit(0);
               miso_idx = 1;
            end else begin
               miso_idx = 0;
            end
         end
         if (busy) begin
            busy_run++;
            if (ss !== exp_ss) ss_bad++;
         end else begin
            idle_run++;
         end
         if (busy && prev_busy) begin
            edge_seen = (sclk !== prev_sclk);
            lead_seen = (sclk !== cfg_cpol);
            if (edge_seen && (lead_seen != cfg_cpha)) mosi_cap = {mosi_cap[6:0], mosi};
            if (edge_seen && (lead_seen == cfg_cpha) && miso_idx < 8) begin
               miso = miso_bit(miso_idx);
               miso_idx++;
            end
            // mosi may only move on the slave's shift edge
            if ((mosi !== prev_mosi) && !(edge_seen && (lead_seen == cfg_cpha))) mosi_tbad++;
         end
         if (done) begin
            done_run++;
            if (done_run > done_max) done_max = done_run;
            if (done_cnt < 32) begin
               data_q[done_cnt] = data_out;
               mosi_q[done_cnt] = mosi_cap;
               busy_q[done_cnt] = busy_run;
            end
            done_cnt++;
         end else begin
            done_run = 0;
         end
         prev_busy = busy;
      end
      prev_sclk = sclk;
      prev_mosi = mosi;
   end

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic start_xfer(input logic [7:0] d, input logic pol, input logic pha,
                             input logic [1:0] sel, input logic [7:0] mw, input logic l,
                             input logic keep);
      int n;
      cfg_cpol = pol;
      cfg_cpha = pha;
      cfg_miso = mw;
      cfg_lsb  = l;
      exp_ss   = 3'b111;
      if (sel < 2'd3) exp_ss[sel] = 1'b0;
      data_in  = d;
      cpol     = pol;
      cpha     = pha;
      ss_sel   = sel;
`ifdef SPI_BIT_ORDER_EN
      lsb_first = l;
`endif
      ready_send = 1'b1;
      n = 0;
      do begin
         tick();
         n++;
      end while (busy !== 1'b1 && n < 10);
      if (busy !== 1'b1) begin
         total++; bad++;
         $display("FAIL start_busy got=%b exp=1", busy);
      end
      if (!keep) ready_send = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n = 0;
      while (done_cnt < target && n < 400) begin
         tick();
         n++;
      end
      if (done_cnt < target) begin
         total++; bad++;
         $display("FAIL wait_done got=%0d exp=%0d", done_cnt, target);
      end
      tick();
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) tick();
      total++; if (ss !== 3'b111)   begin bad++; $display("FAIL rst_ss got=%b exp=111", ss); end
      total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy got=%b exp=0", busy); end
      total++; if (done !== 1'b0)   begin bad++; $display("FAIL rst_done got=%b exp=0", done); end
      total++; if (sclk !== 1'b0)   begin bad++; $display("FAIL rst_sclk got=%b exp=0", sclk); end
      total++; if (mosi !== 1'b0)   begin bad++; $display("FAIL rst_mosi got=%b exp=0", mosi); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL rst_data got=%h exp=00", data_out); end
      rst = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_mode0();
      int base = done_cnt;
      ss_bad = 0; mosi_tbad = 0; done_max = 0;
      start_xfer(8'h13, 1'b0, 1'b0, 2'd0, 8'h37, 1'b0, 1'b0);
      total++; if (ss !== 3'b110) begin bad++; $display("FAIL m0_ss_setup got=%b exp=110", ss); end
      total++; if (mosi !== 1'b0) begin bad++; $display("FAIL m0_mosi_setup got=%b exp=0", mosi); end
      wait_done(base + 1);
      total++; if (mosi_q[base] !== 8'h13) begin bad++; $display("FAIL m0_mosi got=%h exp=13", mosi_q[base]); end
      total++; if (data_q[base] !== 8'h37) begin bad++; $display("FAIL m0_data got=%h exp=37", data_q[base]); end
      total++; if (busy_q[base] != 36) begin bad++; $display("FAIL m0_busy_len got=%0d exp=36", busy_q[base]); end
      total++; if (ss_bad != 0) begin bad++; $display("FAIL m0_ss got=%0d exp=0", ss_bad); end
      total++; if (mosi_tbad != 0) begin bad++; $display("FAIL m0_mosi_timing got=%0d exp=0", mosi_tbad); end
      total++; if (done_max != 1) begin bad++; $display("FAIL m0_done_width got=%0d exp=1", done_max); end
      total++; if (data_out !== 8'h37) begin bad++; $display("FAIL m0_data_hold got=%h exp=37", data_out); end
   endtask

   task automatic test_mode3();
      int base = done_cnt;
      ss_bad = 0; mosi_tbad = 0;
      cpol = 1'b1;
      repeat (2) tick();
      total++; if (sclk !== 1'b1 || ss !== 3'b111) begin bad++; $display("FAIL m3_idle got=%b/%b exp=1/111", sclk, ss); end
      start_xfer(8'h13, 1'b1, 1'b1, 2'd0, 8'h37, 1'b0, 1'b0);
      total++; if (sclk !== 1'b1 || ss !== 3'b110) begin bad++; $display("FAIL m3_setup got=%b/%b exp=1/110", sclk, ss); end
      wait_done(base + 1);
      total++; if (mosi_q[base] !== 8'h13) begin bad++; $display("FAIL m3_mosi got=%h exp=13", mosi_q[base]); end
      total++; if (data_q[base] !== 8'h37) begin bad++; $display("FAIL m3_data got=%h exp=37", data_q[base]); end
      total++; if (mosi_tbad != 0) begin bad++; $display("FAIL m3_mosi_timing got=%0d exp=0", mosi_tbad); end
      total++; if (busy_q[base] != 36) begin bad++; $display("FAIL m3_busy_len got=%0d exp=36", busy_q[base]); end
      total++; if (sclk !== 1'b1) begin bad++; $display("FAIL m3_sclk_end got=%b exp=1", sclk); end
      cpol = 1'b0;
      repeat (2) tick();
   endtask

   task automatic test_ss_sel();
      int base = done_cnt;
      ss_bad = 0;
      start_xfer(8'h81, 1'b0, 1'b0, 2'd2, 8'hA5, 1'b0, 1'b0);
      total++; if (ss !== 3'b011) begin bad++; $display("FAIL sel2_ss got=%b exp=011", ss); end
      wait_done(base + 1);
      total++; if (data_q[base] !== 8'hA5) begin bad++; $display("FAIL sel2_data got=%h exp=a5", data_q[base]); end
      start_xfer(8'h7E, 1'b0, 1'b0, 2'd3, 8'h5A, 1'b0, 1'b0);
      total++; if (ss !== 3'b111) begin bad++; $display("FAIL sel3_ss got=%b exp=111", ss); end
      wait_done(base + 2);
      total++; if (done_cnt != base + 2) begin bad++; $display("FAIL sel3_done got=%0d exp=%0d", done_cnt, base + 2); end
      total++; if (data_q[base+1] !== 8'h5A) begin bad++; $display("FAIL sel3_data got=%h exp=5a", data_q[base+1]); end
      total++; if (ss_bad != 0) begin bad++; $display("FAIL sel_ss_during got=%0d exp=0", ss_bad); end
   endtask

   task automatic test_back_to_back();
      int base = done_cnt;
      int n;
      start_xfer(8'hC3, 1'b0, 1'b0, 2'd1, 8'h37, 1'b0, 1'b1);
      data_in = 8'h3C;
      wait_done(base + 1);
      n = 0;
      while (busy !== 1'b1 && n < 10) begin tick(); n++; end
      ready_send = 1'b0;
      wait_done(base + 2);
      total++; if (gap_last != 1) begin bad++; $display("FAIL b2b_gap got=%0d exp=1", gap_last); end
      total++; if (mosi_q[base] !== 8'hC3) begin bad++; $display("FAIL b2b_mosi0 got=%h exp=c3", mosi_q[base]); end
      total++; if (mosi_q[base+1] !== 8'h3C) begin bad++; $display("FAIL b2b_mosi1 got=%h exp=3c", mosi_q[base+1]); end
      total++; if (busy_q[base+1] != 36) begin bad++; $display("FAIL b2b_busy_len got=%0d exp=36", busy_q[base+1]); end
      // a single ready_send pulse while busy must not start another transfer
      base = done_cnt;
      start_xfer(8'h55, 1'b0, 1'b0, 2'd0, 8'h0F, 1'b0, 1'b0);
      repeat (5) tick();
      ready_send = 1'b1;
      tick();
      ready_send = 1'b0;
      wait_done(base + 1);
      repeat (40) tick();
      total++; if (done_cnt != base + 1 || busy !== 1'b0) begin bad++; $display("FAIL ignore_pulse got=%0d/%b exp=%0d/0", done_cnt, busy, base + 1); end
      total++; if (data_q[base] !== 8'h0F) begin bad++; $display("FAIL ignore_data got=%h exp=0f", data_q[base]); end
   endtask

   task automatic test_reset_mid();
      int base = done_cnt;
      int n = 0;
      start_xfer(8'h13, 1'b0, 1'b0, 2'd0, 8'h37, 1'b0, 1'b0);
      while (busy_run < 13 && n < 40) begin tick(); n++; end
      rst = 1'b1;
      tick();
      total++; if (ss !== 3'b111) begin bad++; $display("FAIL mid_rst_ss got=%b exp=111", ss); end
      total++; if (busy !== 1'b0) begin bad++; $display("FAIL mid_rst_busy got=%b exp=0", busy); end
      total++; if (sclk !== 1'b0) begin bad++; $display("FAIL mid_rst_sclk got=%b exp=0", sclk); end
      total++; if (data_out !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", data_out); end
      rst = 1'b0;
      repeat (50) tick();
      total++; if (done_cnt != base) begin bad++; $display("FAIL mid_rst_done got=%0d exp=%0d", done_cnt, base); end
   endtask

`ifdef SPI_BIT_ORDER_EN
   task automatic test_lsb_first();
      int base = done_cnt;
      start_xfer(8'h13, 1'b0, 1'b0, 2'd0, 8'h37, 1'b1, 1'b0);
      wait_done(base + 1);
      // bits seen in order 1,1,0,0,1,0,0,0 packed first-bit-high
      total++; if (mosi_q[base] !== 8'hC8) begin bad++; $display("FAIL lsb_mosi got=%h exp=c8", mosi_q[base]); end
      total++; if (data_q[base] !== 8'h37) begin bad++; $display("FAIL lsb_data got=%h exp=37", data_q[base]); end
      lsb_first = 1'b0;
   endtask
`endif

   initial begin
      test_reset();
      test_mode0();
      test_mode3();
      test_ss_sel();
      test_back_to_back();
      test_reset_mid();
`ifdef SPI_BIT_ORDER_EN
      test_lsb_first();
`endif
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL global_timeout got=running exp=finished");
      $fatal(1);
   end

endmodule

`default_nettype wire
